// File: rtl/instr_mem_ctrl_if.sv
// Fetch-side bus for the instruction memory controller.
// The master issues fetch requests and the slave returns responses.
interface instr_mem_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a post-reset clear sweep, a program-load
// write port and a one-cycle-latency valid/ready fetch port.
module instr_mem_ctrl #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_mem_ctrl_if.slave        fetch,
    input  logic                   ld_en,
    input  logic [31:0]            ld_addr,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   ld_err,
    output logic                   busy
);

    localparam int AB = $clog2(DATA_W / 8);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     clr_idx_q, clr_idx_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              ld_err_q, ld_err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              req_ok;
    logic              ld_ok;
    logic [IW-1:0]     req_idx;
    logic [IW-1:0]     ld_idx;
    logic              req_rdy;
    logic              req_fire;
    logic              ld_wr;

    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] widx;
        widx = a >> AB;
        return (a[AB-1:0] == '0) && (widx < 32'(DEPTH));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return IW'(a >> AB);
    endfunction

    assign run     = (state_q == RUN);
    assign req_ok  = addr_ok(fetch.req_addr);
    assign ld_ok   = addr_ok(ld_addr);
    assign req_idx = word_idx(fetch.req_addr);
    assign ld_idx  = word_idx(ld_addr);

    // A load owns the cycle; the fetch stalls instead of being dropped.
    assign req_rdy  = run && !ld_en && (!rsp_valid_q || fetch.rsp_ready);
    assign req_fire = fetch.req_valid && req_rdy;
    assign ld_wr    = run && ld_en && ld_ok;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = RUN;
                    clr_idx_d = '0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ld_err_d    = run && ld_en && !ld_ok;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = req_ok ? mem[req_idx] : NOP_WORD;
            rsp_err_d   = !req_ok;
        end else if (fetch.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= NOP_WORD;
            rsp_err_q   <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ld_err_q    <= ld_err_d;
        end
    end

    // Storage has no reset; the clear sweep after reset initialises it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == CLEAR) begin
                mem[clr_idx_q] <= NOP_WORD;
            end else if (ld_wr) begin
                mem[ld_idx] <= ld_data;
            end
        end
    end

    assign fetch.req_ready = req_rdy;
    assign fetch.rsp_valid = rsp_valid_q;
    assign fetch.rsp_data  = rsp_data_q;
    assign fetch.rsp_err   = rsp_err_q;
    assign ld_err          = ld_err_q;
    assign busy            = (state_q == CLEAR);

endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 1024: number of instruction words stored.
REQ-003 Parameter NOP_WORD, default 0 (DATA_W bits): clear value and error-response data.
REQ-004 Derived constant AB = log2(DATA_W/8): alignment bit count; 2 when DATA_W=32, 3 when DATA_W=64.
REQ-005 Port clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n  in  1: synchronous, active-low reset.
REQ-007 Port req_valid  in  1: fetch request valid.
REQ-008 Port req_ready  out  1: fetch request accepted this cycle when req_valid is also high.
REQ-009 Port req_addr  in  32: fetch byte address.
REQ-010 Port rsp_valid  out  1: fetch response valid.
REQ-011 Port rsp_ready  in  1: consumer accepts the response.
REQ-012 Port rsp_data  out  DATA_W: fetched instruction word.
REQ-013 Port rsp_err  out  1: fetch fault, either misaligned or out of range.
REQ-014 Port ld_en  in  1: program-load write strobe.
REQ-015 Port ld_addr  in  32: load byte address.
REQ-016 Port ld_data  in  DATA_W: load data.
REQ-017 Port ld_err  out  1: one-cycle pulse flagging a rejected load.
REQ-018 Port busy  out  1: high while the block is clearing memory.

Function
REQ-019 Word index SHALL be addr >> AB; the address is misaligned if addr[AB-1:0] != 0; the address is out of range if the word index >= DEPTH.
REQ-020 The FSM SHALL have two states, CLEAR and RUN, and reset SHALL enter CLEAR with clr_idx = 0.
REQ-021 In CLEAR, each cycle the block SHALL write NOP_WORD to mem[clr_idx] and increment clr_idx.
- After writing index DEPTH-1, the FSM SHALL go to RUN; CLEAR therefore lasts exactly DEPTH cycles.
- busy SHALL be high throughout CLEAR.
- req_ready SHALL be low throughout CLEAR.
- ld_en SHALL be ignored in CLEAR, with no write and no ld_err.
REQ-022 In RUN, req_ready SHALL equal !ld_en && (!rsp_valid || rsp_ready).
REQ-023 Load behaviour in RUN:
- A legal load (aligned and in range) SHALL write mem[index] at that edge.
- An illegal load SHALL leave memory unchanged and SHALL assert ld_err in the following cycle for one cycle.
REQ-024 Fetch latency: a request accepted at edge N SHALL produce rsp_valid=1 with its data after edge N, i.e. one cycle of latency.
REQ-025 A legal fetch SHALL give rsp_data = mem[index] and rsp_err=0.
REQ-026 An illegal fetch SHALL give rsp_data = NOP_WORD and rsp_err=1.
REQ-027 While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_err SHALL hold stable.
REQ-028 rsp_valid SHALL clear at the edge where rsp_ready=1, unless a new request is accepted at the same edge; in that case rsp_valid SHALL stay 1 and carry the new data (back-to-back, one word per cycle).
REQ-029 Simultaneous ld_en and req_valid: the load wins and the fetch stalls (req_ready=0), so no request is lost.
REQ-030 A fetch accepted in the cycle after a load to the same address SHALL return the newly loaded data.
REQ-031 Memory is read-only to the fetch port; the only writers are the CLEAR sequence and legal loads.

Reset
REQ-032 While rst_n=0 at an edge, all outputs SHALL reset: req_ready=0, rsp_valid=0, rsp_data=NOP_WORD, rsp_err=0, ld_err=0, busy=1.
REQ-033 Reset asserted mid-operation SHALL drop any pending response without handshake and SHALL restart CLEAR from index 0.
REQ-034 Memory contents SHALL NOT be cleared by reset itself, only by the CLEAR sequence that follows it.

Verification
REQ-035 Reset, then count cycles with busy=1 -> exactly 1024 (default DEPTH); then fetch 0x0 -> rsp_data=0x00000000, rsp_err=0.
REQ-036 Load 0x00220800 at 0x4 and 0x00641000 at 0x8; fetch 0x4, then 0x8 back-to-back with rsp_ready=1 -> two consecutive rsp_valid cycles with data 0x00220800, then 0x00641000.
REQ-037 Fetch 0x6 -> rsp_err=1, rsp_data=NOP_WORD. Fetch 0x1000 (index 1024) -> rsp_err=1. Load to 0x1000 -> ld_err pulses once and memory is unchanged.
REQ-038 Hold rsp_ready=0 for 3 cycles after a fetch of 0xC -> rsp_data stable and req_ready=0 for those 3 cycles; on rsp_ready=1, exactly one response is consumed.
REQ-039 Drive ld_en and req_valid in the same cycle, both at 0x10 -> req_ready=0 that cycle; the next-cycle fetch returns the loaded word.
REQ-040 Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 and busy=1 after the edge; the clear restarts and 0x4 reads NOP_WORD afterwards.
